// File: rtl/cache_nway_wb.sv
// cache_nway_wb: N-way set-associative, write-back, write-allocate L1 cache
// between the CPU request port and the AXI bridge. Victim selection prefers
// the lowest invalid way, else a free-running 16-bit LFSR.
// Optional feature macro: CACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt.
module cache_nway_wb #(
  parameter  int WAYS       = 2,
  parameter  int INDEX_W    = 8,
  parameter  int LINE_WORDS = 4,
  localparam int OFFSET_W   = $clog2(LINE_WORDS) + 2,
  localparam int TAG_W      = 32 - INDEX_W - OFFSET_W
) (
  input  logic                    clk_g,
  input  logic                    resetn,
  input  logic                    valid,
  input  logic                    op,
  input  logic [INDEX_W-1:0]      index,
  input  logic [TAG_W-1:0]        tag,
  input  logic [OFFSET_W-1:0]     offset,
  input  logic [3:0]              wstrb,
  input  logic [31:0]             wdata,
  output logic                    addr_ok,
  output logic                    data_ok,
  output logic [31:0]             rdata,
  output logic                    rd_req,
  output logic [2:0]              rd_type,
  output logic [31:0]             rd_addr,
  input  logic                    rd_rdy,
  input  logic                    ret_valid,
  input  logic                    ret_last,
  input  logic [31:0]             ret_data,
  output logic                    wr_req,
  output logic [2:0]              wr_type,
  output logic [31:0]             wr_addr,
  output logic [3:0]              wr_wstrb,
  output logic [32*LINE_WORDS-1:0] wr_data,
  input  logic                    wr_rdy
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);
  localparam int SETS   = 1 << INDEX_W;
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_MISS    = 3'd2,
    S_REPLACE = 3'd3,
    S_REFILL  = 3'd4
  } state_t;

  localparam logic WB_IDLE  = 1'b0;
  localparam logic WB_WRITE = 1'b1;

  // Byte-masked word merge shared by write buffer, refill merge and forwarding.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [3:0]  strb,
                                             input logic [31:0] new_word);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  state_t state_r, state_next_s;
  logic   wb_state_r, wb_next_s;

  // request buffer
  logic               req_op_r;
  logic [INDEX_W-1:0] req_index_r;
  logic [TAG_W-1:0]   req_tag_r;
  logic [WORD_W-1:0]  req_word_r;
  logic [3:0]         req_wstrb_r;
  logic [31:0]        req_wdata_r;

  // storage arrays and their synchronous-read registers
  logic [TAG_W-1:0]             tag_mem  [WAYS][SETS];
  logic [LINE_WORDS-1:0][31:0]  data_mem [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0]    valid_mem;
  logic [WAYS-1:0][SETS-1:0]    dirty_mem;
  logic [TAG_W-1:0]             rd_tag_r  [WAYS];
  logic [LINE_WORDS-1:0][31:0]  rd_line_r [WAYS];

  // write buffer
  logic [WAY_W-1:0]   wb_way_r;
  logic [INDEX_W-1:0] wb_index_r;
  logic [WORD_W-1:0]  wb_word_r;
  logic [3:0]         wb_wstrb_r;
  logic [31:0]        wb_wdata_r;

  // victim and refill bookkeeping
  logic [WAY_W-1:0]            victim_way_r;
  logic [TAG_W-1:0]            victim_tag_r;
  logic                        victim_dirty_r;
  logic [LINE_WORDS-1:0][31:0] victim_data_r;
  logic [WORD_W-1:0]           beat_cnt_r;
  logic [31:0]                 saved_word_r;
  logic [15:0]                 lfsr_r;

  // combinational lookup results
  logic [LINE_WORDS-1:0][31:0] lookup_line_s [WAYS];
  logic [WAYS-1:0]             hit_vec_s;
  logic                        hit_s;
  logic [WAY_W-1:0]            hit_way_s;
  logic [31:0]                 hit_word_s;
  logic [WAY_W-1:0]            victim_s;
  logic                        victim_valid_s;
  logic                        victim_dirty_s;
  logic [TAG_W-1:0]            victim_tag_s;
  logic [LINE_WORDS-1:0][31:0] victim_line_s;
  logic                        hazard_s;
  logic [WORD_W-1:0]           in_word_s;
  logic                        wb_write_s;
  logic [31:0]                 refill_beat_s;
  logic [31:0]                 refill_rdata_s;
  logic                        refill_done_s;
  logic                        unused_bits_s;

  assign in_word_s     = offset[OFFSET_W-1:2];
  assign wb_write_s    = (wb_state_r == WB_WRITE);
  assign refill_done_s = (state_r == S_REFILL) && ret_valid && ret_last;
  assign refill_beat_s = (req_op_r && (beat_cnt_r == req_word_r))
                         ? byte_merge(ret_data, req_wstrb_r, req_wdata_r) : ret_data;
  assign refill_rdata_s = (beat_cnt_r == req_word_r) ? refill_beat_s : saved_word_r;
  assign rd_type   = 3'b100;
  assign wr_type   = 3'b100;
  assign wr_wstrb  = 4'hf;
  assign rd_addr   = {req_tag_r, req_index_r, {OFFSET_W{1'b0}}};
  assign wr_addr   = {victim_tag_r, req_index_r, {OFFSET_W{1'b0}}};
  assign wr_data   = victim_data_r;
  assign unused_bits_s = ^{offset[1:0], lfsr_r};

  // Tag compare, hit word select, victim choice and read-after-write hazard.
  always_comb begin
    lookup_line_s  = rd_line_r;
    hit_vec_s      = '0;
    hit_way_s      = '0;
    hit_word_s     = 32'h0;
    victim_valid_s = 1'b0;
    victim_dirty_s = 1'b0;
    victim_tag_s   = '0;
    victim_line_s  = '0;
    victim_s       = (WAYS > 1) ? lfsr_r[WAY_W-1:0] : '0;
    for (int w = 0; w < WAYS; w++) begin
      // forward a write-buffer store that lands while this line is being looked at
      for (int k = 0; k < LINE_WORDS; k++) begin
        if (wb_write_s && (wb_index_r == req_index_r) && (wb_way_r == WAY_W'(w)) &&
            (wb_word_r == WORD_W'(k))) begin
          lookup_line_s[w][k] = byte_merge(rd_line_r[w][k], wb_wstrb_r, wb_wdata_r);
        end else begin
          lookup_line_s[w][k] = rd_line_r[w][k];
        end
      end
      hit_vec_s[w] = valid_mem[w][req_index_r] && (rd_tag_r[w] == req_tag_r);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec_s[w]) hit_way_s = WAY_W'(w);
      if (!valid_mem[w][req_index_r]) victim_s = WAY_W'(w);
    end
    hit_s = |hit_vec_s;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_way_s == WAY_W'(w)) begin
        for (int k = 0; k < LINE_WORDS; k++) begin
          if (req_word_r == WORD_W'(k)) hit_word_s = lookup_line_s[w][k];
        end
      end
      if (victim_s == WAY_W'(w)) begin
        victim_valid_s = valid_mem[w][req_index_r];
        victim_dirty_s = dirty_mem[w][req_index_r] ||
                         (wb_write_s && (wb_index_r == req_index_r) && (wb_way_r == WAY_W'(w)));
        victim_tag_s   = rd_tag_r[w];
        victim_line_s  = lookup_line_s[w];
      end
    end
    hazard_s = !op &&
               ((wb_write_s && (wb_index_r == index) && (wb_word_r == in_word_s)) ||
                ((state_r == S_LOOKUP) && hit_s && req_op_r &&
                 (req_index_r == index) && (req_word_r == in_word_s)));
  end

  // Main FSM state and write-buffer state registers.
  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      state_r    <= S_IDLE;
      wb_state_r <= WB_IDLE;
    end else begin
      state_r    <= state_next_s;
      wb_state_r <= wb_next_s;
    end
  end

  // Next-state logic for the main FSM and the write buffer.
  always_comb begin
    state_next_s = state_r;
    wb_next_s    = (state_r == S_LOOKUP && hit_s && req_op_r) ? WB_WRITE : WB_IDLE;
    case (state_r)
      S_IDLE:    state_next_s = addr_ok ? S_LOOKUP : S_IDLE;
      S_LOOKUP: begin
        if (hit_s) state_next_s = addr_ok ? S_LOOKUP : S_IDLE;
        else       state_next_s = S_MISS;
      end
      S_MISS: begin
        if (victim_dirty_r) state_next_s = wr_rdy ? S_REPLACE : S_MISS;
        else                state_next_s = S_REPLACE;
      end
      S_REPLACE: state_next_s = rd_rdy ? S_REFILL : S_REPLACE;
      S_REFILL:  state_next_s = (ret_valid && ret_last) ? S_IDLE : S_REFILL;
      default:   state_next_s = S_IDLE;
    endcase
  end

  // Handshake outputs derived from the current state.
  always_comb begin
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rdata   = 32'h0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    if (!resetn) begin
      addr_ok = 1'b0;
    end else begin
      case (state_r)
        S_IDLE:    addr_ok = valid && !hazard_s;
        S_LOOKUP: begin
          if (hit_s) begin
            data_ok = 1'b1;
            rdata   = hit_word_s;
            addr_ok = valid && !hazard_s;
          end else begin
            addr_ok = 1'b0;
          end
        end
        S_MISS:    wr_req = victim_dirty_r;
        S_REPLACE: rd_req = 1'b1;
        S_REFILL: begin
          if (refill_done_s) begin
            data_ok = 1'b1;
            rdata   = refill_rdata_s;
          end else begin
            data_ok = 1'b0;
          end
        end
        default:   addr_ok = 1'b0;
      endcase
    end
  end

  // Request buffer: latch the accepted request.
  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      req_op_r    <= 1'b0;
      req_index_r <= '0;
      req_tag_r   <= '0;
      req_word_r  <= '0;
      req_wstrb_r <= 4'h0;
      req_wdata_r <= 32'h0;
    end else if (addr_ok) begin
      req_op_r    <= op;
      req_index_r <= index;
      req_tag_r   <= tag;
      req_word_r  <= in_word_s;
      req_wstrb_r <= wstrb;
      req_wdata_r <= wdata;
    end
  end

  // Synchronous array read on acceptance, forwarding a same-cycle buffer store.
  always_ff @(posedge clk_g) begin
    if (addr_ok) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_tag_r[w] <= tag_mem[w][index];
        for (int k = 0; k < LINE_WORDS; k++) begin
          if (wb_write_s && (wb_index_r == index) && (wb_way_r == WAY_W'(w)) &&
              (wb_word_r == WORD_W'(k))) begin
            rd_line_r[w][k] <= byte_merge(data_mem[w][index][k], wb_wstrb_r, wb_wdata_r);
          end else begin
            rd_line_r[w][k] <= data_mem[w][index][k];
          end
        end
      end
    end
  end

  // Capture the victim way, tag, dirtiness and line on a lookup miss.
  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      victim_way_r   <= '0;
      victim_tag_r   <= '0;
      victim_dirty_r <= 1'b0;
      victim_data_r  <= '0;
    end else if (state_r == S_LOOKUP && !hit_s) begin
      victim_way_r   <= victim_s;
      victim_tag_r   <= victim_tag_s;
      victim_dirty_r <= victim_valid_s && victim_dirty_s;
      victim_data_r  <= victim_line_s;
    end
  end

  // Refill beat counter and the requested word seen during refill.
  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      beat_cnt_r   <= '0;
      saved_word_r <= 32'h0;
    end else if (state_r != S_REFILL) begin
      beat_cnt_r <= '0;
    end else if (ret_valid) begin
      beat_cnt_r <= beat_cnt_r + WORD_W'(1);
      if (beat_cnt_r == req_word_r) saved_word_r <= refill_beat_s;
    end
  end

  // Write buffer payload, loaded by a write hit in lookup.
  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      wb_way_r   <= '0;
      wb_index_r <= '0;
      wb_word_r  <= '0;
      wb_wstrb_r <= 4'h0;
      wb_wdata_r <= 32'h0;
    end else if (state_r == S_LOOKUP && hit_s && req_op_r) begin
      wb_way_r   <= hit_way_s;
      wb_index_r <= req_index_r;
      wb_word_r  <= req_word_r;
      wb_wstrb_r <= req_wstrb_r;
      wb_wdata_r <= req_wdata_r;
    end
  end

  // Valid and dirty bits: cleared by reset, updated by refill and buffer store.
  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      valid_mem <= '0;
      dirty_mem <= '0;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (wb_write_s && wb_way_r == WAY_W'(w)) dirty_mem[w][wb_index_r] <= 1'b1;
        if (refill_done_s && victim_way_r == WAY_W'(w)) begin
          valid_mem[w][req_index_r] <= 1'b1;
          dirty_mem[w][req_index_r] <= req_op_r;
        end
      end
    end
  end

  // Tag and data arrays: buffer stores and refill beats, never during reset.
  always_ff @(posedge clk_g) begin
    if (resetn) begin
      for (int w = 0; w < WAYS; w++) begin
        if (wb_write_s && wb_way_r == WAY_W'(w)) begin
          data_mem[w][wb_index_r][wb_word_r] <=
            byte_merge(data_mem[w][wb_index_r][wb_word_r], wb_wstrb_r, wb_wdata_r);
        end
        if (state_r == S_REFILL && ret_valid && victim_way_r == WAY_W'(w)) begin
          data_mem[w][req_index_r][beat_cnt_r] <= refill_beat_s;
          if (ret_last) tag_mem[w][req_index_r] <= req_tag_r;
        end
      end
    end
  end

  // Free-running replacement LFSR (x^16 + x^14 + x^13 + x^11 + 1).
  always_ff @(posedge clk_g) begin
    if (!resetn) lfsr_r <= 16'hACE1;
    else         lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
  end

`ifdef CACHE_PERF_CNT_EN
  // Saturating hit/miss counters, one count per lookup outcome.
  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else if (state_r == S_LOOKUP) begin
      if (hit_s) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'h1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed self-checking bench for cache_nway_wb (WAYS=2, INDEX_W=8, LINE_WORDS=4).
module tb_cache_nway_wb;
  logic         clk_g = 1'b0;
  logic         resetn;
  logic         valid, op;
  logic [7:0]   index;
  logic [19:0]  tag;
  logic [3:0]   offset, wstrb;
  logic [31:0]  wdata;
  logic         addr_ok, data_ok, rd_req, wr_req;
  logic [31:0]  rdata, rd_addr, wr_addr;
  logic [2:0]   rd_type, wr_type;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         rd_rdy, ret_valid, ret_last, wr_rdy;
  logic [31:0]  ret_data;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk_g = ~clk_g;

  cache_nway_wb #(.WAYS(2), .INDEX_W(8), .LINE_WORDS(4)) dut (
    .clk_g(clk_g), .resetn(resetn), .valid(valid), .op(op), .index(index), .tag(tag),
    .offset(offset), .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data), .wr_req(wr_req),
    .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data),
    .wr_rdy(wr_rdy)
`ifdef CACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk_g);
  endtask

  task automatic to_pos();
    @(posedge clk_g);
    #1;
  endtask

  // Present a request and wait (bounded) for its acceptance edge.
  task automatic send(input logic o, input logic [7:0] ix, input logic [19:0] tg,
                      input logic [3:0] of, input logic [3:0] st, input logic [31:0] wd,
                      output int waits);
    logic got;
    got = 1'b0;
    waits = 0;
    valid = 1'b1; op = o; index = ix; tag = tg; offset = of; wstrb = st; wdata = wd;
    for (int i = 0; i < 8; i++) begin
      to_neg();
      if (addr_ok === 1'b1) begin
        got = 1'b1;
        waits = i;
        break;
      end
      to_pos();
    end
    check("accept", {127'b0, got}, 128'd1);
    to_pos();
    valid = 1'b0; op = 1'b0; wstrb = 4'h0; wdata = 32'h0;
  endtask

  // Wait (bounded) for the line read request, check it, then grant it.
  task automatic expect_rd_req(input logic [31:0] exp_addr, input logic exp_wr);
    logic seen_rd, seen_wr;
    seen_rd = 1'b0;
    seen_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      to_neg();
      if (wr_req === 1'b1) seen_wr = 1'b1;
      if (rd_req === 1'b1) begin
        seen_rd = 1'b1;
        break;
      end
      to_pos();
    end
    check("rd_req_seen", {127'b0, seen_rd}, 128'd1);
    check("rd_addr", {96'b0, rd_addr}, {96'b0, exp_addr});
    check("rd_type", {125'b0, rd_type}, {125'b0, 3'b100});
    check("wr_req_seen", {127'b0, seen_wr}, {127'b0, exp_wr});
    rd_rdy = 1'b1;
    to_pos();
    rd_rdy = 1'b0;
  endtask

  // Return four beats base..base+3; data_ok only with the last one.
  task automatic refill(input logic [31:0] base, input logic [31:0] exp_rdata);
    for (int b = 0; b < 4; b++) begin
      ret_valid = 1'b1;
      ret_data  = base + 32'(b);
      ret_last  = (b == 3);
      to_neg();
      if (b == 3) begin
        check("refill_data_ok", {127'b0, data_ok}, 128'd1);
        check("refill_rdata", {96'b0, rdata}, {96'b0, exp_rdata});
      end else begin
        check("refill_early_data_ok", {127'b0, data_ok}, 128'd0);
      end
      to_pos();
    end
    ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
  endtask

  initial begin
    int w;
    logic [127:0] line_a, line_b;
    resetn = 1'b0; valid = 1'b1; op = 1'b0; index = 8'h0; tag = 20'h0; offset = 4'h0;
    wstrb = 4'h0; wdata = 32'h0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
    ret_data = 32'h0; wr_rdy = 1'b0;
    line_a = {32'hA3, 32'h0000_5555, 32'hA1, 32'hA0};
    line_b = {32'hB3, 32'hB2, 32'hDEAD_BEEF, 32'hB0};

    // reset state
    to_pos(); to_pos(); to_pos();
    to_neg();
    check("reset_outputs", {91'b0, addr_ok, data_ok, rd_req, wr_req, rdata},
          {91'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    valid = 1'b0;
    to_pos();
    resetn = 1'b1;
    to_pos();

    // cold read miss idx 5, tag 0x1234, offset 8
    send(1'b0, 8'd5, 20'h01234, 4'd8, 4'h0, 32'h0, w);
    check("cold_accept_wait", 128'(w), 128'd0);
    to_neg();
    check("cold_lookup_data_ok", {127'b0, data_ok}, 128'd0);
    to_pos();
    expect_rd_req(32'h0123_4050, 1'b0);
    refill(32'hA0, 32'hA2);

    // repeat read: hit one cycle after acceptance, no AXI traffic
    send(1'b0, 8'd5, 20'h01234, 4'd8, 4'h0, 32'h0, w);
    to_neg();
    check("hit_data_ok", {127'b0, data_ok}, 128'd1);
    check("hit_rdata", {96'b0, rdata}, {96'b0, 32'hA2});
    check("hit_no_axi", {126'b0, rd_req, wr_req}, 128'd0);
    to_pos();

    // write hit then immediate read of the same word
    send(1'b1, 8'd5, 20'h01234, 4'd8, 4'b0011, 32'hFFFF_5555, w);
    valid = 1'b1; op = 1'b0; index = 8'd5; tag = 20'h01234; offset = 4'd8;
    to_neg();
    check("wr_hit_data_ok", {127'b0, data_ok}, 128'd1);
    check("raw_hazard_lookup", {127'b0, addr_ok}, 128'd0);
    to_pos();
    send(1'b0, 8'd5, 20'h01234, 4'd8, 4'h0, 32'h0, w);
    check("raw_hazard_wait", 128'(w), 128'd1);
    to_neg();
    check("raw_read_data_ok", {127'b0, data_ok}, 128'd1);
    check("raw_read_rdata", {96'b0, rdata}, {96'b0, 32'h0000_5555});
    to_pos();

    // write miss fills way 1 of idx 5 with a dirty line
    send(1'b1, 8'd5, 20'h02222, 4'd4, 4'hf, 32'hDEAD_BEEF, w);
    to_neg();
    check("wmiss_data_ok", {127'b0, data_ok}, 128'd0);
    to_pos();
    expect_rd_req(32'h0222_2050, 1'b0);
    refill(32'hB0, 32'hDEAD_BEEF);

    // third tag evicts a dirty victim; wr_rdy withheld for 3 cycles
    send(1'b0, 8'd5, 20'h03333, 4'd0, 4'h0, 32'h0, w);
    to_neg();
    check("evict_lookup_data_ok", {127'b0, data_ok}, 128'd0);
    to_pos();
    to_neg();
    check("evict_wr_req", {127'b0, wr_req}, 128'd1);
    check("evict_rd_req_low", {127'b0, rd_req}, 128'd0);
    check("evict_wr_type", {125'b0, wr_type}, {125'b0, 3'b100});
    check("evict_wr_wstrb", {124'b0, wr_wstrb}, {124'b0, 4'hf});
    check("evict_wr_addr_is_line",
          {127'b0, (wr_addr === 32'h0123_4050) || (wr_addr === 32'h0222_2050)}, 128'd1);
    if (wr_addr === 32'h0123_4050) check("evict_wr_data_way_a", wr_data, line_a);
    else                           check("evict_wr_data_way_b", wr_data, line_b);
    for (int i = 0; i < 3; i++) begin
      to_pos();
      to_neg();
      check("evict_wr_req_held", {127'b0, wr_req}, 128'd1);
    end
    wr_rdy = 1'b1;
    to_pos();
    wr_rdy = 1'b0;
    expect_rd_req(32'h0333_3050, 1'b0);
    refill(32'hC0, 32'hC0);

    // four back-to-back read hits
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; op = 1'b0; index = 8'd5; tag = 20'h03333; offset = 4'(4 * i);
      to_neg();
      check("b2b_addr_ok", {127'b0, addr_ok}, 128'd1);
      if (i > 0) begin
        check("b2b_data_ok", {127'b0, data_ok}, 128'd1);
        check("b2b_rdata", {96'b0, rdata}, {96'b0, 32'hC0 + 32'(i - 1)});
      end
      to_pos();
    end
    valid = 1'b0;
    to_neg();
    check("b2b_last_data_ok", {127'b0, data_ok}, 128'd1);
    check("b2b_last_rdata", {96'b0, rdata}, {96'b0, 32'hC3});
    to_pos();

    // reset during the second refill beat
    send(1'b0, 8'd7, 20'h00055, 4'd0, 4'h0, 32'h0, w);
    to_pos();
    expect_rd_req(32'h0005_5070, 1'b0);
    ret_valid = 1'b1; ret_data = 32'hD0; ret_last = 1'b0;
    to_pos();
    ret_data = 32'hD1; resetn = 1'b0; valid = 1'b1; index = 8'd7; tag = 20'h00055;
    to_neg();
    check("midrefill_reset_outputs", {91'b0, addr_ok, data_ok, rd_req, wr_req, rdata},
          {91'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    to_pos();
    resetn = 1'b1; ret_valid = 1'b0; valid = 1'b0; ret_data = 32'h0;
    to_pos();
    send(1'b0, 8'd7, 20'h00055, 4'd0, 4'h0, 32'h0, w);
    check("post_reset_accept_wait", 128'(w), 128'd0);
    to_neg();
    check("post_reset_miss", {127'b0, data_ok}, 128'd0);
    to_pos();
    expect_rd_req(32'h0005_5070, 1'b0);
    refill(32'hE0, 32'hE0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
